// File: rtl/atomik_pkg.sv
// Shared definitions for the atomik core and delta decoder.
//   DEPTH_DEF / ADDR_W_DEF : default address space
//   PAT_W                  : pattern width
//   ev_kind_e              : decoded event kind (DROP, FIRST, DELTA, NONE)
//   cell_t                 : one state-RAM word {seeded, pattern}
package atomik_pkg;

   localparam int DEPTH_DEF  = 625;
   localparam int ADDR_W_DEF = 10;
   localparam int PAT_W      = 4;

   typedef enum logic [1:0] {
      EV_DROP  = 2'd0,
      EV_FIRST = 2'd1,
      EV_DELTA = 2'd2,
      EV_NONE  = 2'd3
   } ev_kind_e;

   typedef struct packed {
      logic             seeded;
      logic [PAT_W-1:0] pat;
   } cell_t;

   // Drop beats everything (explicit invalid or address out of range),
   // then first-touch, then delta.
   function automatic ev_kind_e ev_classify(input logic drop_invalid,
                                            input logic first_touch,
                                            input logic delta,
                                            input logic in_range);
      if (drop_invalid || !in_range) return EV_DROP;
      if (first_touch)               return EV_FIRST;
      if (delta)                     return EV_DELTA;
      return EV_NONE;
   endfunction

endpackage

// File: rtl/atomik_state_ram.sv
// DEPTH x 5-bit state store: {seeded, pattern} per address.
//   clk          : clock
//   we/waddr/wdata : write port, committed on rising edge
//   raddr/rdata  : asynchronous read port with write-first bypass, so a
//                  read of the address being written this cycle returns
//                  the incoming data.
// The array has no reset; the owner sweeps it clean after reset.
module atomik_state_ram
   import atomik_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = ADDR_W_DEF
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [4:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [4:0]    rdata
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [4:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we && ({1'b0, waddr} < DEPTH_C)) mem[waddr] <= wdata;
   end

   always_comb begin
      rdata = '0;
      if (we && (waddr == raddr))          rdata = wdata;
      else if ({1'b0, raddr} < DEPTH_C)    rdata = mem[raddr];
   end

endmodule

// File: rtl/atomik_delta_decoder.sv
// Delta-stream decoder: reconstructs absolute 4-bit patterns per address
// from first-touch seeds and XOR deltas.
//   clk, rst            : clock, synchronous active-high reset
//   ev_*                : event stream in (valid/ready handshake)
//   out_*               : reconstructed pattern out (valid/ready handshake)
//   busy                : high while the state store is being cleared
//   err_unseeded        : sticky, delta seen on an unseeded address
//   drop_count          : saturating count of dropped events
// Optional build macro ATOMIK_DECODER_ZERO_SUPPRESS_EN: zero-valued deltas
// produce no write and no output.
module atomik_delta_decoder
   import atomik_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ev_valid,
   input  logic              ev_delta,
   input  logic              ev_first_touch,
   input  logic              ev_drop_invalid,
   input  logic [ADDR_W-1:0] ev_addr,
   input  logic [3:0]        ev_delta_val,
   input  logic [3:0]        ev_seed_val,
   output logic              ev_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [3:0]        out_pattern,
   output logic              out_fresh,
   output logic              busy,
   output logic              err_unseeded,
   output logic [15:0]       drop_count
);

   localparam logic CLEAR = 1'b0;
   localparam logic RUN   = 1'b1;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   logic              fsm;
   logic [ADDR_W-1:0] ptr;

   // Event results are written back one cycle after acceptance; the RAM
   // bypass covers a same-address event in that cycle.
   logic              pend_we;
   logic [ADDR_W-1:0] pend_addr;
   cell_t             pend_cell;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [4:0]        ram_wdata;
   logic [4:0]        ram_rdata;
   cell_t             cur;

   ev_kind_e          kind;
   logic              accept;
   logic              zero_sup;
   logic              emit;
   logic              wr;
   logic              set_err;
   cell_t             wr_cell;

   assign busy     = (fsm == CLEAR);
   assign ev_ready = (fsm == RUN) && (!out_valid || out_ready);
   assign accept   = ev_valid && ev_ready;

   always_comb begin
      ram_we    = pend_we;
      ram_waddr = pend_addr;
      ram_wdata = pend_cell;
      if (fsm == CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = ptr;
         ram_wdata = '0;
      end
   end

   atomik_state_ram #(.DEPTH(DEPTH), .AW(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ev_addr),
      .rdata (ram_rdata)
   );

   assign cur  = cell_t'(ram_rdata);
   assign kind = ev_classify(ev_drop_invalid, ev_first_touch, ev_delta,
                             {1'b0, ev_addr} < DEPTH_C);

`ifdef ATOMIK_DECODER_ZERO_SUPPRESS_EN
   assign zero_sup = (ev_delta_val == 4'h0);
`else
   assign zero_sup = 1'b0;
`endif

   always_comb begin
      emit    = 1'b0;
      wr      = 1'b0;
      set_err = 1'b0;
      wr_cell = '0;
      case (kind)
         EV_FIRST: begin
            emit    = 1'b1;
            wr      = 1'b1;
            wr_cell = '{seeded: 1'b1, pat: ev_seed_val};
         end
         EV_DELTA: begin
            if (!cur.seeded) begin
               set_err = 1'b1;
            end else if (!zero_sup) begin
               emit    = 1'b1;
               wr      = 1'b1;
               wr_cell = '{seeded: 1'b1, pat: cur.pat ^ ev_delta_val};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm          <= CLEAR;
         ptr          <= '0;
         pend_we      <= 1'b0;
         pend_addr    <= '0;
         pend_cell    <= '0;
         out_valid    <= 1'b0;
         out_addr     <= '0;
         out_pattern  <= '0;
         out_fresh    <= 1'b0;
         err_unseeded <= 1'b0;
         drop_count   <= '0;
      end else begin
         if (fsm == CLEAR) begin
            if (ptr == LAST) fsm <= RUN;
            else             ptr <= ptr + 1'b1;
         end

         pend_we   <= accept && wr;
         pend_addr <= ev_addr;
         pend_cell <= wr_cell;

         if (accept && (kind == EV_DROP) && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
         if (accept && set_err)
            err_unseeded <= 1'b1;

         if (accept && emit) begin
            out_valid   <= 1'b1;
            out_addr    <= ev_addr;
            out_pattern <= wr_cell.pat;
            out_fresh   <= (kind == EV_FIRST);
         end else if (out_ready) begin
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_pattern <= '0;
            out_fresh   <= 1'b0;
         end
      end
   end

endmodule
